vslc_prog_loader: RTL and testbench

//  Upstream program loader for the VSLC nibble stack core. Receives a framed program over a
//  3-wire serial link (cs_n/sck/mosi, mode 0, MSB first), unpacks bytes into 4-bit opcodes and

---
 rtl/vslc_pkg.sv | 19 +
 rtl/vslc_sync_edge.sv | 34 +++
 rtl/vslc_prog_loader.sv | 175 +++++++++++++++++
 tb/tb_vslc_prog_loader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vslc_pkg.sv
// Shared definitions for the VSLC nibble stack core and its program loader.
package vslc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_FILL,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  localparam logic [3:0] OP_NOP        = 4'hF;
  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam logic [3:0] NOP_DEFAULT   = OP_NOP;

endpackage

// File: rtl/vslc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detection
// on the synchronized value.
module vslc_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/vslc_prog_loader.sv
// Serial program loader: deframes MAGIC/LEN/data/CSUM from a mode-0 link,
// writes opcode nibbles into code memory, pads with NOP and gates the core.
module vslc_prog_loader
  import vslc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT,
  parameter logic [3:0]  NOP_CODE    = NOP_DEFAULT,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [3:0]        prog_data,
  output logic              core_hold,
  output logic              prog_done,
  output logic              prog_err
);

  localparam logic [ADDR_W:0] NIB_FULL = {1'b1, {ADDR_W{1'b0}}};

  // NOTE: reset asserts asynchronously but releases on a clock edge, so no
  // flop sees the deassertion inside its recovery window.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic cs_s, cs_rise, cs_fall;
  logic sck_s_unused, sck_rise, sck_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  vslc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_int_n), .d_i(spi_cs_n),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  vslc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_int_n), .d_i(spi_sck),
    .q_o(sck_s_unused), .rise_o(sck_rise), .fall_o(sck_fall_unused)
  );
  vslc_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_int_n), .d_i(spi_mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  loader_state_e     state_q;
  logic [6:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        sum_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   nib_cnt_q;
  logic [ADDR_W:0]   nib_len_q;
  logic              we_q;
  logic [3:0]        data_q;
  logic              hold_q, done_q, err_q;

  logic              in_frame, bit_ev, byte_ev, nib_ev;
  logic [7:0]        byte_w;
  logic [ADDR_W-1:0] fill_addr;

  // byte_w[3:0] is also the completed high nibble when bit_cnt_q == 3.
  assign byte_w    = {shift_q, mosi_s};
  assign in_frame  = state_q inside {ST_HDR, ST_LEN, ST_DATA, ST_CSUM};
  assign bit_ev    = sck_rise && !cs_s && in_frame;
  assign byte_ev   = bit_ev && (bit_cnt_q == 3'd7);
  assign nib_ev    = bit_ev && (bit_cnt_q[1:0] == 2'd3);
  // The address counter lags a strobe by one clk; this is the next free slot.
  assign fill_addr = addr_q + ADDR_W'(we_q);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sum_q     <= '0;
      addr_q    <= '0;
      nib_cnt_q <= '0;
      nib_len_q <= '0;
      we_q      <= 1'b0;
      data_q    <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (we_q) addr_q <= addr_q + ADDR_W'(1);

      if (cs_fall) begin
        state_q   <= ST_HDR;
        bit_cnt_q <= '0;
        sum_q     <= '0;
        nib_cnt_q <= '0;
        addr_q    <= '0;
        hold_q    <= 1'b1;
        done_q    <= 1'b0;
        err_q     <= 1'b0;
      end else if (cs_rise && in_frame) begin
        state_q <= ST_ERR;
        err_q   <= 1'b1;
      end else begin
        if (bit_ev) begin
          shift_q   <= byte_w[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end

        unique case (state_q)
          ST_HDR: begin
            if (byte_ev) begin
              if (byte_w == MAGIC) begin
                state_q <= ST_LEN;
              end else begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end
            end
          end
          ST_LEN: begin
            if (byte_ev) begin
              nib_len_q <= (byte_w == 8'd0) ? NIB_FULL : (ADDR_W+1)'(byte_w);
              state_q   <= ST_DATA;
            end
          end
          ST_DATA: begin
            // An odd-length program leaves the final low nibble unwritten.
            if (nib_ev && (nib_cnt_q < nib_len_q)) begin
              we_q      <= 1'b1;
              data_q    <= byte_w[3:0];
              nib_cnt_q <= nib_cnt_q + (ADDR_W+1)'(1);
            end
            if (byte_ev) begin
              sum_q <= sum_q + byte_w;
              if (nib_cnt_q >= nib_len_q - (ADDR_W+1)'(1)) state_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (byte_ev) begin
              if (8'(sum_q + byte_w) == 8'd0) begin
                state_q <= nib_len_q[ADDR_W] ? ST_DONE : ST_FILL;
              end else begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end
            end
          end
          ST_FILL: begin
            we_q   <= 1'b1;
            data_q <= NOP_CODE;
            if (fill_addr == '1) state_q <= ST_DONE;
          end
          ST_DONE: begin
            hold_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign prog_we   = we_q;
  assign prog_addr = addr_q;
  assign prog_data = data_q;
  assign core_hold = hold_q;
  assign prog_done = done_q;
  assign prog_err  = err_q;

endmodule

// File: tb/tb_vslc_prog_loader.sv
// Directed bench for vslc_prog_loader: drives framed programs over the serial
// link and checks the recorded write stream and status flags.
module tb_vslc_prog_loader;

  localparam int HALF = 50;  // sck half period: 5 clk, above the 4-clk minimum

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_cs_n = 1'b1;
  logic       spi_sck  = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       prog_we;
  logic [7:0] prog_addr;
  logic [3:0] prog_data;
  logic       core_hold, prog_done, prog_err;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  logic [7:0] rec_addr [4096];
  logic [3:0] rec_data [4096];
  logic [3:0] exp_img  [256];

  always #5 clk = ~clk;

  vslc_prog_loader dut (
    .clk(clk), .rst_n(rst_n),
    .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .core_hold(core_hold), .prog_done(prog_done), .prog_err(prog_err)
  );

  // Write recorder, sampling on the falling clock edge.
  always @(negedge clk) begin
    if (prog_we === 1'b1) begin
      if (wr_cnt < 4096) begin
        rec_addr[wr_cnt] = prog_addr;
        rec_data[wr_cnt] = prog_data;
      end
      wr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      #HALF; spi_sck = 1'b1;
      #HALF; spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] b);
    spi_bits(b, 8);
  endtask

  // Sends the n low-order bytes of seq, most significant first.
  task automatic send_seq(input logic [63:0] seq, input int n);
    for (int j = n - 1; j >= 0; j--) spi_byte(seq[j*8 +: 8]);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_high();
    #HALF;
    spi_cs_n = 1'b1;
  endtask

  task automatic wait_settle();
    int i;
    i = 0;
    while (i < 2000 && prog_done !== 1'b1 && prog_err !== 1'b1) begin
      @(posedge clk);
      i++;
    end
    wait_clks(4);
  endtask

  // Number of the 256 writes from base that differ from addr k / exp_img[k].
  function automatic int image_errors(input int base);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (rec_addr[base+k] !== 8'(k) || rec_data[base+k] !== exp_img[k]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #21;
    n_cmp++;
    if ({prog_we, prog_addr, prog_data} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_data: we/addr/data got %h, required 0", {prog_we, prog_addr, prog_data});
    end
    n_cmp++;
    if ({core_hold, prog_done, prog_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_flags: hold/done/err got %b, required 100", {core_hold, prog_done, prog_err});
    end
    rst_n = 1'b1;
    wait_clks(6);
    n_cmp++;
    if ({prog_we, core_hold, prog_done, prog_err} !== 4'b0100) begin
      n_bad++;
      $display("FAIL idle_flags: we/hold/done/err got %b, required 0100",
               {prog_we, core_hold, prog_done, prog_err});
    end
  endtask

  // 0x12 + 0x34 = 0x46, so CSUM = 0x100 - 0x46 = 0xBA.
  task automatic test_basic();
    int base, bad;
    for (int k = 0; k < 256; k++) exp_img[k] = 4'hF;
    exp_img[0] = 4'h1; exp_img[1] = 4'h2; exp_img[2] = 4'h3; exp_img[3] = 4'h4;
    base = wr_cnt;
    cs_low();
    send_seq(64'hA5_04_12_34_BA, 5);
    cs_high();
    wait_settle();
    n_cmp++;
    if (wr_cnt - base != 256) begin
      n_bad++;
      $display("FAIL basic_writes: got %0d strobes, required 256", wr_cnt - base);
    end
    bad = image_errors(base);
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL basic_image: %0d wrong writes, required 0", bad);
    end
    n_cmp++;
    if ({prog_done, core_hold, prog_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL basic_flags: done/hold/err got %b, required 100", {prog_done, core_hold, prog_err});
    end
  endtask

  // Odd length; 0x9A + 0xB0 = 0x14A -> 0x4A, CSUM = 0xB6.
  task automatic test_odd_len();
    int base, bad;
    for (int k = 0; k < 256; k++) exp_img[k] = 4'hF;
    exp_img[0] = 4'h9; exp_img[1] = 4'hA; exp_img[2] = 4'hB;
    base = wr_cnt;
    cs_low();
    n_cmp++;
    if ({core_hold, prog_done} !== 2'b10) begin
      n_bad++;
      $display("FAIL odd_csfall: hold/done got %b, required 10", {core_hold, prog_done});
    end
    send_seq(64'hA5_03_9A_B0_B6, 5);
    cs_high();
    wait_settle();
    n_cmp++;
    if (wr_cnt - base != 256) begin
      n_bad++;
      $display("FAIL odd_writes: got %0d strobes, required 256", wr_cnt - base);
    end
    n_cmp++;
    if ({rec_addr[base+3], rec_data[base+3]} !== 12'h03F) begin
      n_bad++;
      $display("FAIL odd_first_fill: addr/data got %h, required 03f", {rec_addr[base+3], rec_data[base+3]});
    end
    bad = image_errors(base);
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL odd_image: %0d wrong writes, required 0", bad);
    end
    n_cmp++;
    if ({prog_done, core_hold, prog_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL odd_flags: done/hold/err got %b, required 100", {prog_done, core_hold, prog_err});
    end
  endtask

  task automatic test_bad_csum();
    int base;
    base = wr_cnt;
    cs_low();
    send_seq(64'hA5_02_12_00, 4);
    cs_high();
    wait_settle();
    n_cmp++;
    if (wr_cnt - base != 2) begin
      n_bad++;
      $display("FAIL csum_writes: got %0d strobes, required 2", wr_cnt - base);
    end
    n_cmp++;
    if ({rec_addr[base], rec_data[base], rec_addr[base+1], rec_data[base+1]} !== 24'h001012) begin
      n_bad++;
      $display("FAIL csum_data: got %h, required 001012",
               {rec_addr[base], rec_data[base], rec_addr[base+1], rec_data[base+1]});
    end
    n_cmp++;
    if ({prog_done, core_hold, prog_err} !== 3'b011) begin
      n_bad++;
      $display("FAIL csum_flags: done/hold/err got %b, required 011", {prog_done, core_hold, prog_err});
    end
  endtask

  // Bad header, then a good frame: 0xAB -> CSUM 0x55.
  task automatic test_bad_magic();
    int base, bad;
    base = wr_cnt;
    cs_low();
    spi_byte(8'h5A);
    wait_clks(2);
    n_cmp++;
    if ({prog_err, core_hold} !== 2'b11) begin
      n_bad++;
      $display("FAIL magic_err: err/hold got %b, required 11", {prog_err, core_hold});
    end
    send_seq(64'h04_12_34_BA, 4);
    cs_high();
    wait_clks(10);
    n_cmp++;
    if (wr_cnt - base != 0) begin
      n_bad++;
      $display("FAIL magic_writes: got %0d strobes, required 0", wr_cnt - base);
    end
    for (int k = 0; k < 256; k++) exp_img[k] = 4'hF;
    exp_img[0] = 4'hA; exp_img[1] = 4'hB;
    base = wr_cnt;
    cs_low();
    n_cmp++;
    if ({prog_err, core_hold, prog_done} !== 3'b010) begin
      n_bad++;
      $display("FAIL magic_clear: err/hold/done got %b, required 010", {prog_err, core_hold, prog_done});
    end
    send_seq(64'hA5_02_AB_55, 4);
    cs_high();
    wait_settle();
    bad = image_errors(base);
    n_cmp++;
    if (bad != 0 || wr_cnt - base != 256) begin
      n_bad++;
      $display("FAIL magic_reload: %0d wrong of %0d strobes, required 0 of 256", bad, wr_cnt - base);
    end
    n_cmp++;
    if ({prog_done, core_hold, prog_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL magic_done: done/hold/err got %b, required 100", {prog_done, core_hold, prog_err});
    end
  endtask

  task automatic test_cs_abort();
    int base;
    base = wr_cnt;
    cs_low();
    send_seq(64'hA5_04, 2);
    spi_bits(8'h12, 5);
    cs_high();
    wait_settle();
    n_cmp++;
    if (wr_cnt - base != 1) begin
      n_bad++;
      $display("FAIL abort_writes: got %0d strobes, required 1", wr_cnt - base);
    end
    n_cmp++;
    if ({rec_addr[base], rec_data[base]} !== 12'h001) begin
      n_bad++;
      $display("FAIL abort_data: addr/data got %h, required 001", {rec_addr[base], rec_data[base]});
    end
    n_cmp++;
    if ({prog_done, core_hold, prog_err} !== 3'b011) begin
      n_bad++;
      $display("FAIL abort_flags: done/hold/err got %b, required 011", {prog_done, core_hold, prog_err});
    end
  endtask

  task automatic test_full_len();
    int base, bad;
    logic [7:0] b, sum;
    sum = 8'h00;
    for (int i = 0; i < 128; i++) begin
      b = 8'(i * 37 + 5);
      exp_img[2*i]   = b[7:4];
      exp_img[2*i+1] = b[3:0];
      sum = sum + b;
    end
    base = wr_cnt;
    cs_low();
    send_seq(64'hA5_00, 2);
    for (int i = 0; i < 128; i++) spi_byte(8'(i * 37 + 5));
    spi_byte(8'h00 - sum);
    cs_high();
    wait_settle();
    n_cmp++;
    if (wr_cnt - base != 256) begin
      n_bad++;
      $display("FAIL full_writes: got %0d strobes, required 256", wr_cnt - base);
    end
    bad = image_errors(base);
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL full_image: %0d wrong writes, required 0", bad);
    end
    n_cmp++;
    if (prog_addr !== 8'h00) begin
      n_bad++;
      $display("FAIL full_wrap: prog_addr got %h, required 00", prog_addr);
    end
    n_cmp++;
    if ({prog_done, core_hold, prog_err} !== 3'b100) begin
      n_bad++;
      $display("FAIL full_flags: done/hold/err got %b, required 100", {prog_done, core_hold, prog_err});
    end
  endtask

  task automatic test_reset_mid();
    int base;
    base = wr_cnt;
    cs_low();
    send_seq(64'hA5_00, 2);
    repeat (10) spi_byte(8'h11);
    n_cmp++;
    if (wr_cnt - base != 20) begin
      n_bad++;
      $display("FAIL rstmid_pre: got %0d strobes, required 20", wr_cnt - base);
    end
    spi_bits(8'h11, 3);
    #4;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({prog_we, prog_addr, prog_data, core_hold, prog_done, prog_err} !== 16'h0004) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got %h, required 0004",
               {prog_we, prog_addr, prog_data, core_hold, prog_done, prog_err});
    end
    base = wr_cnt;
    repeat (3) spi_byte(8'h11);
    spi_cs_n = 1'b1;
    #17;
    rst_n = 1'b1;
    wait_clks(8);
    n_cmp++;
    if (wr_cnt - base != 0) begin
      n_bad++;
      $display("FAIL rstmid_writes: got %0d strobes, required 0", wr_cnt - base);
    end
    n_cmp++;
    if ({prog_we, core_hold, prog_done, prog_err} !== 4'b0100) begin
      n_bad++;
      $display("FAIL rstmid_flags: we/hold/done/err got %b, required 0100",
               {prog_we, core_hold, prog_done, prog_err});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_len();
    test_bad_csum();
    test_bad_magic();
    test_cs_abort();
    test_full_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
